i2c_master: RTL

- Single-byte I2C bus master; the initiator side of the bus that the switch and LED slaves respond to.
- Performs one transaction per request: START, 7-bit address plus R/W, one data byte (write, or read with master NACK), STOP.
- Sits between the system controller (e.g. a UART command decoder) and the board I2C bus on the Basys3.
- Drives SCL push-pull (no clock stretching) and SDA open-drain.

---
 rtl/i2c_master_if.sv | 25 ++
 rtl/i2c_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_if.sv
// Handshake and SCL signals between a bus controller (e.g. a UART command
// decoder) and the single-byte I2C master. The open-drain SDA pad is not
// part of this bundle; it is a plain inout on the master.
interface i2c_master_if;
    logic       start;
    logic       rw;
    logic [6:0] slave_addr;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       ack_error;
    logic       scl;
    logic [3:0] debug_state;

    modport master (
        input  start, rw, slave_addr, tx_data,
        output rx_data, busy, done, ack_error, scl, debug_state
    );

    modport slave (
        output start, rw, slave_addr, tx_data,
        input  rx_data, busy, done, ack_error, scl, debug_state
    );
endinterface

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address + R/W, one data byte (write, or read
// finished with a master NACK), STOP. SCL is push-pull, SDA is open-drain.
// Every phase is four quarter-bit periods; bus outputs are registered and are
// always loaded with the levels belonging to the quarter about to begin.
module i2c_master #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int I2C_FREQ = 100_000
) (
    input  logic         clk,
    input  logic         rst_n,
    i2c_master_if.master bus,
    inout  wire          sda
);
    localparam int QUARTER = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    if (QUARTER < 4) begin : g_quarter_check
        $error("i2c_master: CLK_FREQ/(4*I2C_FREQ) must be at least 4");
    end

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP
    } state_t;

    state_t          state;
    logic [QW-1:0]   q_cnt;
    logic [1:0]      quarter;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [6:0]      rx_shift;
    logic            rw_r;
    logic [7:0]      tx_r;
    logic            scl_r;
    logic            oe_r;
    logic            busy_r;
    logic            done_r;
    logic            ack_err_r;
    logic [7:0]      rx_r;
    logic            sda_meta;
    logic            sda_sync;
    logic            tick;

    assign tick = (q_cnt == QW'(QUARTER - 1));

    // SCL level and SDA pull-down enable for a given state, quarter and outgoing bit.
    function automatic logic [1:0] bus_drive(input state_t s, input logic [1:0] q,
                                             input logic bit_val);
        logic [1:0] r;
        r = 2'b10;
        case (s)
            START:                             r = {(q != 2'd3), q[1]};
            ADDR, WR_DATA:                     r = {q[1], ~bit_val};
            ADDR_ACK, WR_ACK, RD_DATA, RD_NACK: r = {q[1], 1'b0};
            STOP:                              r = {(q != 2'd0), ~q[1]};
            default:                           r = 2'b10;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser on the incoming SDA level; idles high like the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= sda;
            sda_sync <= sda_meta;
        end
    end

    // Transaction FSM: quarter timing, bit shifting, sampling and registered bus levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            q_cnt     <= '0;
            quarter   <= 2'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rx_shift  <= 7'h00;
            rw_r      <= 1'b0;
            tx_r      <= 8'h00;
            scl_r     <= 1'b1;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
            rx_r      <= 8'h00;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    rw_r           <= bus.rw;
                    tx_r           <= bus.tx_data;
                    shreg          <= {bus.slave_addr, bus.rw};
                    busy_r         <= 1'b1;
                    ack_err_r      <= 1'b0;
                    q_cnt          <= '0;
                    quarter        <= 2'd0;
                    bit_cnt        <= 3'd0;
                    state          <= START;
                    {scl_r, oe_r}  <= bus_drive(START, 2'd0, 1'b1);
                end
            end else if (!tick) begin
                q_cnt <= q_cnt + 1'b1;
            end else if (quarter != 2'd3) begin
                q_cnt         <= '0;
                quarter       <= quarter + 2'd1;
                {scl_r, oe_r} <= bus_drive(state, quarter + 2'd1, shreg[7]);
            end else begin
                q_cnt   <= '0;
                quarter <= 2'd0;
                case (state)
                    START: begin
                        bit_cnt       <= 3'd0;
                        state         <= ADDR;
                        {scl_r, oe_r} <= bus_drive(ADDR, 2'd0, shreg[7]);
                    end
                    ADDR, WR_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            state         <= (state == ADDR) ? ADDR_ACK : WR_ACK;
                            {scl_r, oe_r} <= bus_drive(ADDR_ACK, 2'd0, 1'b1);
                        end else begin
                            bit_cnt       <= bit_cnt + 3'd1;
                            shreg         <= {shreg[6:0], 1'b0};
                            {scl_r, oe_r} <= bus_drive(state, 2'd0, shreg[6]);
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt <= 3'd0;
                        if (sda_sync) begin
                            ack_err_r     <= 1'b1;
                            state         <= STOP;
                            {scl_r, oe_r} <= bus_drive(STOP, 2'd0, 1'b1);
                        end else if (rw_r) begin
                            state         <= RD_DATA;
                            {scl_r, oe_r} <= bus_drive(RD_DATA, 2'd0, 1'b1);
                        end else begin
                            shreg         <= tx_r;
                            state         <= WR_DATA;
                            {scl_r, oe_r} <= bus_drive(WR_DATA, 2'd0, tx_r[7]);
                        end
                    end
                    WR_ACK: begin
                        if (sda_sync) begin
                            ack_err_r <= 1'b1;
                        end
                        state         <= STOP;
                        {scl_r, oe_r} <= bus_drive(STOP, 2'd0, 1'b1);
                    end
                    RD_DATA: begin
                        rx_shift <= {rx_shift[5:0], sda_sync};
                        if (bit_cnt == 3'd7) begin
                            rx_r          <= {rx_shift, sda_sync};
                            state         <= RD_NACK;
                            {scl_r, oe_r} <= bus_drive(RD_NACK, 2'd0, 1'b1);
                        end else begin
                            bit_cnt       <= bit_cnt + 3'd1;
                            {scl_r, oe_r} <= bus_drive(RD_DATA, 2'd0, 1'b1);
                        end
                    end
                    RD_NACK: begin
                        state         <= STOP;
                        {scl_r, oe_r} <= bus_drive(STOP, 2'd0, 1'b1);
                    end
                    STOP: begin
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        state         <= IDLE;
                        {scl_r, oe_r} <= bus_drive(IDLE, 2'd0, 1'b1);
                    end
                    default: begin
                        busy_r        <= 1'b0;
                        state         <= IDLE;
                        {scl_r, oe_r} <= bus_drive(IDLE, 2'd0, 1'b1);
                    end
                endcase
            end
        end
    end

    assign sda             = oe_r ? 1'b0 : 1'bz;
    assign bus.scl         = scl_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.ack_error   = ack_err_r;
    assign bus.rx_data     = rx_r;
    assign bus.debug_state = state;
endmodule
